// File: rtl/pattern_det_param.sv
// Serial pattern detector: matches the last W valid input bits against a loadable
// pattern, emits a registered one-cycle pulse and keeps a saturating match count.
module pattern_det_param #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic [W-1:0]     pattern,
  input  logic             pat_load,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FILL_W = $clog2(W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(W);

  logic [W-1:0]      pat_q,  pat_d;
  logic [W-1:0]      hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              out_q,  out_d;
  logic [CNT_W-1:0]  cnt_q,  cnt_d;

  logic [W-1:0]      hist_shift;
  logic [FILL_W-1:0] fill_inc;
  logic              match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign hist_shift = {hist_q[W-2:0], in};
  assign fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
  // The fill check keeps an all-zero pattern from matching the cleared history.
  assign match      = in_valid && !pat_load && (fill_inc == FILL_FULL) && (hist_shift == pat_q);

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    cnt_d  = cnt_q;
    if (pat_load) begin
      pat_d  = pattern;
      hist_d = '0;
      fill_d = '0;
    end else if (in_valid) begin
      hist_d = hist_shift;
      fill_d = fill_inc;
      if (match) begin
        out_d = 1'b1;
        cnt_d = sat_inc(cnt_q);
        if (!overlap) fill_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= '0;
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out       = out_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = &cnt_q;

endmodule

// File: doc/pattern_det_param.md
PATTERN_DET_PARAM -- requirements
Module: pattern_det_param

Interface
REQ-001 The block SHALL take parameter W, default 4, as the pattern length in bits; legal range 2..32.
REQ-002 The block SHALL take parameter CNT_W, default 8, as the match counter width in bits; legal range 1..32.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in, input, 1 bit: serial data bit.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in is sampled only when high.
REQ-007 The block SHALL have port pattern, input, W bits: the target pattern, captured only on pat_load.
REQ-008 The block SHALL have port pat_load, input, 1 bit: captures pattern and clears history.
REQ-009 The block SHALL have port overlap, input, 1 bit: 1 = overlapping matches, 0 = non-overlapping matches.
REQ-010 The block SHALL have port out, output, 1 bit: registered match pulse.
REQ-011 The block SHALL have port match_cnt, output, CNT_W bits: saturating count of matches.
REQ-012 The block SHALL have port cnt_sat, output, 1 bit: high while match_cnt equals all-ones.

Function
REQ-013 Internal state SHALL be: pattern register pat_q (W bits), history shift register hist (W bits), fill counter fill (0..W), out register, and match_cnt.
REQ-014 On each edge with in_valid=1 and pat_load=0, hist SHALL shift left with in entering bit 0, so the oldest bit sits in hist[W-1] and pattern[W-1] is the first bit expected.
REQ-015 On the same edge, fill SHALL increment, saturating at W.
REQ-016 A match SHALL be declared on that edge when the post-shift fill equals W and the post-shift hist equals pat_q.
REQ-017 On a match, out SHALL be 1 for exactly the following cycle, so latency is 1 cycle from the edge sampling the final pattern bit.
REQ-018 On every edge without a match, out SHALL be 0, including cycles with in_valid=0.
REQ-019 On a match with overlap=1, hist and fill SHALL be retained, so the pattern's suffix can start the next match.
REQ-020 On a match with overlap=0, fill SHALL be cleared to 0, so a new match needs W fresh valid bits.
REQ-021 overlap SHALL be sampled on the match edge only; changing it mid-stream SHALL NOT alter the stored history.
REQ-022 Cycles with in_valid=0 SHALL hold hist and fill unchanged; gaps SHALL NOT break a partial match.
REQ-023 When pat_load=1, pat_q SHALL load pattern, hist and fill SHALL clear to 0, and out SHALL be 0 next cycle.
REQ-024 If pat_load and in_valid are both 1 on the same edge, pat_load SHALL take priority and the in bit SHALL be discarded.
REQ-025 On each match, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1 with no wrap.
REQ-026 cnt_sat SHALL be combinationally equal to (match_cnt == all-ones).
REQ-027 pat_load SHALL NOT clear match_cnt; only reset SHALL clear it.
REQ-028 No match SHALL be declared before W valid bits have been received since reset or pat_load, even when pat_q is all zeros.

Reset
REQ-029 When rst=0, all state SHALL clear immediately and asynchronously, regardless of clk: out=0, match_cnt=0, cnt_sat=0, hist=0, fill=0, pat_q=0.
REQ-030 Reset deassertion SHALL take effect at the first rising edge of clk with rst=1; inputs sampled at that edge SHALL be processed normally.
REQ-031 Asserting rst mid-pattern SHALL discard the partial history; an out pulse already in flight SHALL drop at once.

Verification
REQ-032 Scenario, overlap on: W=4, load 4'b1011, overlap=1, stream 1,0,1,1,0,1,1 -> out pulses after the 4th and 7th bit, match_cnt=2.
REQ-033 Scenario, overlap off: same stream with overlap=0 -> out pulses after the 4th bit only, match_cnt=1.
REQ-034 Scenario, valid gaps and all-zero pattern: load 4'b0000, send 0,0,0 then in_valid=0 for 3 cycles, then 0 -> no pulse until the 4th valid 0, then exactly one pulse.
REQ-035 Scenario, load collision: pat_load=1 with in_valid=1 mid-stream -> history cleared, in bit dropped, no pulse for the next 3 valid bits, match_cnt unchanged.
REQ-036 Scenario, saturation: CNT_W=2, drive 5 matches -> match_cnt sequence 1,2,3,3,3; cnt_sat=1 from the 3rd match onward.
REQ-037 Scenario, async reset: rst=0 asserted between clock edges right after a match edge -> out and match_cnt are 0 before the next edge, and after release a full W bits are needed to match.
